// File: rtl/dmem_arb_pkg.sv
// Shared types for the d_memory arbiter: FSM states, read-owner tag, wait counter width.
// Latency: n/a (types only).
// Backpressure: n/a.
package dmem_arb_pkg;

  typedef enum logic {CORE_PRI, DMA_PRI} arb_state_t;
  typedef enum logic {OWN_CORE, OWN_DMA} owner_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// DMA starvation guard: counts consecutive denied DMA cycles and raises flip to hand DMA priority.
// Latency: flip is combinational in the cycle of the MAX_WAIT-th consecutive denial.
// Backpressure: none; observes grants only.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  arb_state_t state,
  input  logic       dma_req,
  input  logic       dma_gnt,
  output logic       flip
);

  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              denied;

  assign denied = dma_req & ~dma_gnt;
  assign flip   = (state == CORE_PRI) & denied & (wait_cnt == WAIT_LAST);

  // Entering DMA_PRI restarts the count so the next episode waits the full budget.
  always_comb begin
    wait_nxt = wait_cnt;
    if (!dma_req || dma_gnt || flip) begin
      wait_nxt = '0;
    end else if (state == CORE_PRI && denied && wait_cnt != WAIT_MAX) begin
      wait_nxt = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_nxt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter in front of d_memory with starvation guard and tagged read return; perf counters under DMEM_ARB_PERF_EN.
// Latency: grant and mem_* combinational; read data returned one cycle after the granted read.
// Backpressure: loser is held off by gnt=0 (core_stall for the core); requests stay asserted until granted.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_stall,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           perf_core_cnt,
  output logic [31:0]           perf_dma_cnt,
  output logic [31:0]           perf_conflict_cnt
);

  arb_state_t            state;
  arb_state_t            state_nxt;
  owner_t                rd_owner;
  logic                  rd_pending;
  logic                  flip;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (!reset) begin
      if (state == CORE_PRI) begin
        core_gnt = core_req;
        dma_gnt  = dma_req & ~core_req;
      end else begin
        dma_gnt  = dma_req;
        core_gnt = core_req & ~dma_req;
      end
    end
  end

  assign core_stall = core_req & ~core_gnt;

  // Idle cycles replay the last address/data so the memory bus does not toggle.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (core_gnt) begin
      mem_read  = ~core_we;
      mem_write = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dma_gnt) begin
      mem_read  = ~dma_we;
      mem_write = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CORE_PRI: if (flip) state_nxt = DMA_PRI;
      DMA_PRI:  if (dma_gnt || !dma_req) state_nxt = CORE_PRI;
      default:  state_nxt = CORE_PRI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CORE_PRI;
      rd_pending <= 1'b0;
      rd_owner   <= OWN_CORE;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      rd_pending <= mem_read;
      rd_owner   <= dma_gnt ? OWN_DMA : OWN_CORE;
      addr_q     <= mem_addr;
      wdata_q    <= mem_wdata;
    end
  end

  assign core_rvalid = rd_pending & (rd_owner == OWN_CORE);
  assign dma_rvalid  = rd_pending & (rd_owner == OWN_DMA);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign dma_rdata   = dma_rvalid  ? mem_rdata : '0;

  dmem_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_ctr (
    .clk    (clk),
    .reset  (reset),
    .state  (state),
    .dma_req(dma_req),
    .dma_gnt(dma_gnt),
    .flip   (flip)
  );

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_core_cnt     <= '0;
      perf_dma_cnt      <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (core_gnt)           perf_core_cnt     <= perf_core_cnt + 32'd1;
      if (dma_gnt)            perf_dma_cnt      <= perf_dma_cnt + 32'd1;
      if (core_req & dma_req) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`else
  assign perf_core_cnt     = '0;
  assign perf_dma_cnt      = '0;
  assign perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural d_memory (1-cycle read latency).
// Inputs change 1 time unit after posedge; outputs are checked 3 units after posedge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] perf_core_cnt, perf_dma_cnt, perf_conflict_cnt;

  logic [31:0] mem_arr [0:255];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .perf_core_cnt(perf_core_cnt), .perf_dma_cnt(perf_dma_cnt), .perf_conflict_cnt(perf_conflict_cnt)
  );

  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr[9:2]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem_arr[mem_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    logic [5:0] exp_core6, exp_dma6;
    logic [9:0] exp_dma10;
    exp_core6 = 6'b101111;
    exp_dma6  = 6'b010000;
    exp_dma10 = 10'b1000010000;

    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[4] = 32'hDEADBEEF;
    mem_arr[0] = 32'h0000000A;
    mem_arr[1] = 32'h0000000B;

    // Reset with both ports requesting: nothing may be granted.
    reset = 1'b1;
    set_core(1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(1'b1, 1'b0, 32'h4, 32'h0);
    tick(); #2;
    chk("rst_core_gnt", {31'b0, core_gnt}, 32'd0);
    chk("rst_dma_gnt", {31'b0, dma_gnt}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_core_rvalid", {31'b0, core_rvalid}, 32'd0);
    chk("rst_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    chk("rst_perf_conflict", perf_conflict_cnt, 32'd0);

    tick();
    reset = 1'b0;
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);

    // Core-only read of 0x10.
    tick();
    set_core(1'b1, 1'b0, 32'h10, 32'h0);
    #2;
    chk("t1_core_gnt", {31'b0, core_gnt}, 32'd1);
    chk("t1_mem_read", {31'b0, mem_read}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_dma_gnt", {31'b0, dma_gnt}, 32'd0);
    tick();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    chk("t1_core_rvalid", {31'b0, core_rvalid}, 32'd1);
    chk("t1_core_rdata", core_rdata, 32'hDEADBEEF);
    chk("t1_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("t1_dma_rdata", dma_rdata, 32'd0);
    chk("t1_idle_mem_read", {31'b0, mem_read}, 32'd0);
    chk("t1_idle_addr_hold", mem_addr, 32'h10);

    // Both request every cycle: DMA forced in after four denials.
    for (int i = 0; i < 6; i++) begin
      tick();
      set_core(1'b1, 1'b0, 32'h0, 32'h0);
      set_dma(1'b1, 1'b0, 32'h4, 32'h0);
      #2;
      chk($sformatf("t2_core_gnt_c%0d", i), {31'b0, core_gnt}, {31'b0, exp_core6[i]});
      chk($sformatf("t2_dma_gnt_c%0d", i), {31'b0, dma_gnt}, {31'b0, exp_dma6[i]});
      chk($sformatf("t2_core_stall_c%0d", i), {31'b0, core_stall}, {31'b0, exp_dma6[i]});
      if (i == 4) begin
        chk("t2_core_ret_rvalid", {31'b0, core_rvalid}, 32'd1);
        chk("t2_core_ret_rdata", core_rdata, 32'hA);
      end
      if (i == 5) begin
        chk("t2_dma_ret_rvalid", {31'b0, dma_rvalid}, 32'd1);
        chk("t2_dma_ret_rdata", dma_rdata, 32'hB);
        chk("t2_dma_ret_core_rv", {31'b0, core_rvalid}, 32'd0);
      end
    end
    tick();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    chk("t2_last_core_rvalid", {31'b0, core_rvalid}, 32'd1);
    chk("t2_last_core_rdata", core_rdata, 32'hA);
    chk("t2_last_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);

    // Core write 0x20 and DMA read 0x20 in the same cycle.
    tick();
    set_core(1'b1, 1'b1, 32'h20, 32'h1234);
    set_dma(1'b1, 1'b0, 32'h20, 32'h0);
    #2;
    chk("t3_core_gnt", {31'b0, core_gnt}, 32'd1);
    chk("t3_dma_gnt", {31'b0, dma_gnt}, 32'd0);
    chk("t3_mem_write", {31'b0, mem_write}, 32'd1);
    chk("t3_mem_wdata", mem_wdata, 32'h1234);
    tick();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    chk("t3_dma_gnt2", {31'b0, dma_gnt}, 32'd1);
    chk("t3_mem_read2", {31'b0, mem_read}, 32'd1);
    chk("t3_mem_addr2", mem_addr, 32'h20);
    chk("t3_no_wr_rvalid", {31'b0, core_rvalid}, 32'd0);
    tick();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    chk("t3_dma_rvalid", {31'b0, dma_rvalid}, 32'd1);
    chk("t3_dma_rdata", dma_rdata, 32'h1234);
    chk("t3_core_rvalid", {31'b0, core_rvalid}, 32'd0);

    // Alternating owners: core read 0x0 then DMA read 0x4.
    tick();
    set_core(1'b1, 1'b0, 32'h0, 32'h0);
    #2;
    chk("t4_core_gnt", {31'b0, core_gnt}, 32'd1);
    tick();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b1, 1'b0, 32'h4, 32'h0);
    #2;
    chk("t4_dma_gnt", {31'b0, dma_gnt}, 32'd1);
    chk("t4_core_rvalid", {31'b0, core_rvalid}, 32'd1);
    chk("t4_core_rdata", core_rdata, 32'hA);
    chk("t4_dma_rdata_0", dma_rdata, 32'h0);
    tick();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    chk("t4_dma_rvalid", {31'b0, dma_rvalid}, 32'd1);
    chk("t4_dma_rdata", dma_rdata, 32'hB);
    chk("t4_core_rdata_0", core_rdata, 32'h0);

    // Build up DMA wait count, then reset right after a granted core read.
    for (int i = 0; i < 3; i++) begin
      tick();
      set_core(1'b1, 1'b0, 32'h10, 32'h0);
      set_dma(1'b1, 1'b0, 32'h4, 32'h0);
    end
    tick();
    reset = 1'b1;
    #2;
    chk("t5_rst_core_rvalid", {31'b0, core_rvalid}, 32'd0);
    chk("t5_rst_core_rdata", core_rdata, 32'd0);
    chk("t5_rst_core_gnt", {31'b0, core_gnt}, 32'd0);
    chk("t5_rst_mem_read", {31'b0, mem_read}, 32'd0);

    // Post-reset: CORE_PRI with cleared wait count, ten dual-request cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      reset = 1'b0;
      #2;
      if (i == 0) begin
        chk("t5_post_core_rvalid", {31'b0, core_rvalid}, 32'd0);
        chk("t5_post_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
      end
      chk($sformatf("t5_dma_gnt_c%0d", i), {31'b0, dma_gnt}, {31'b0, exp_dma10[i]});
      chk($sformatf("t5_core_gnt_c%0d", i), {31'b0, core_gnt}, {31'b0, ~exp_dma10[i]});
    end
    tick();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
`ifdef DMEM_ARB_PERF_EN
    chk("perf_conflict", perf_conflict_cnt, 32'd10);
    chk("perf_core", perf_core_cnt, 32'd8);
    chk("perf_dma", perf_dma_cnt, 32'd2);
    chk("perf_sum", perf_core_cnt + perf_dma_cnt, 32'd10);
`else
    chk("perf_conflict_off", perf_conflict_cnt, 32'd0);
    chk("perf_core_off", perf_core_cnt, 32'd0);
    chk("perf_dma_off", perf_dma_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Single-port arbiter placed in front of the d_memory instance.
- Shares d_memory between the core MEM stage (core port) and a DMA/debug master (dma port).
- Core has default priority. A starvation guard forces a DMA grant after bounded waiting.
- Returns read data with an owner tag and drives a pipeline stall for the core when it loses arbitration.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- MAX_WAIT, 4, consecutive denied DMA cycles before DMA is given priority (legal 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core access request (level, held until granted)
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_WIDTH  core address
- core_wdata  in  DATA_WIDTH  core write data
- core_gnt  out  1  core request accepted this cycle
- core_stall  out  1  core_req & ~core_gnt; fed into the combined stall
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_WIDTH  core read data
- dma_req  in  1  DMA access request (level)
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_WIDTH  DMA address
- dma_wdata  in  DATA_WIDTH  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DATA_WIDTH  DMA read data
- mem_read  out  1  to d_memory mem_read
- mem_write  out  1  to d_memory mem_write
- mem_addr  out  ADDR_WIDTH  to d_memory addr
- mem_wdata  out  DATA_WIDTH  to d_memory wdata
- mem_rdata  in  DATA_WIDTH  from d_memory rdata; valid 1 cycle after mem_read
- perf_core_cnt  out  32  core grants (optional feature)
- perf_dma_cnt  out  32  DMA grants (optional feature)
- perf_conflict_cnt  out  32  cycles with both requests (optional feature)

Behaviour:
- Arbitration:
  - Combinational grant; at most one grant per cycle.
  - mem_* outputs are muxed combinationally from the winner.
  - With no grant, mem_read = mem_write = 0, and mem_addr/mem_wdata hold their last driven value.
- FSM, 2 states:
  - CORE_PRI (reset state): core_req wins; dma wins only if core_req = 0.
  - DMA_PRI: dma_req wins; core wins only if dma_req = 0.
- Wait counter wait_cnt (4-bit):
  - In CORE_PRI, increments when dma_req & ~dma_gnt.
  - Clears when dma_gnt = 1 or dma_req = 0.
  - Saturates at MAX_WAIT.
- Transitions:
  - CORE_PRI -> DMA_PRI when wait_cnt == MAX_WAIT-1 and another denial occurs, so DMA wins on the next cycle.
  - DMA_PRI -> CORE_PRI after exactly one DMA grant, or immediately if dma_req drops.
  - wait_cnt clears on entry to DMA_PRI.
- Reads:
  - On a granted read, register rd_pending = 1 and rd_owner = winner.
  - Next cycle: owner's rvalid = 1 and owner's rdata = mem_rdata. The other port's rdata = 0.
  - Back-to-back reads from alternating owners are supported; each return follows its own tag.
- Writes: single cycle; no rvalid is produced.
- Simultaneous events:
  - A DMA grant in the same cycle as the core's previous read return is legal.
  - rvalid for a read and a new grant may coincide.
- Reset (asynchronous, active-high):
  - Forces state CORE_PRI, wait_cnt = 0, rd_pending = 0.
  - All rvalid = 0, all rdata = 0, perf counters = 0.
  - gnt and mem_read/mem_write evaluate to 0 while reset = 1.
  - Reset mid-read drops the pending return; no rvalid follows deassertion.
- Worst-case wait: core stall ≤ 1 cycle per DMA_PRI episode; DMA wait ≤ MAX_WAIT cycles.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - perf_core_cnt and perf_dma_cnt increment on each grant.
  - perf_conflict_cnt increments on each cycle with core_req & dma_req.
  - All three are 32-bit wrapping counters.
- Undefined: the three perf outputs are tied to 0 and no counter flops are built. Ports are present in both builds.

Decomposition:
- Package dmem_arb_pkg holds:
  - arb_state_t {CORE_PRI, DMA_PRI}
  - owner_t {OWN_CORE, OWN_DMA}
  - WAIT_W = 4
- One sub-module, dmem_arb_starve_ctr, holds the wait counter, the saturation logic and the priority-flip output. The arbiter core stays in the top level.

Test Plan:
- Core-only read of addr 0x10, memory preloaded with 0xDEADBEEF -> core_gnt=1 the same cycle; core_rvalid=1 with core_rdata=0xDEADBEEF next cycle; dma_rvalid=0.
- Both request every cycle, MAX_WAIT=4 -> core granted cycles 0–3, DMA granted cycle 4, core cycle 5; core_stall=1 only in cycle 4.
- Core write 0x20=0x1234 and DMA read 0x20 requested in the same cycle -> core wins, write lands; DMA granted next cycle and dma_rdata=0x1234.
- Alternating core read 0x0 and DMA read 0x4 (data 0xA, 0xB) -> returns tagged correctly; core_rdata=0xA and dma_rdata=0xB on consecutive cycles.
- Reset asserted the cycle after a granted read -> no rvalid on either port; state CORE_PRI; outputs 0.
- With DMEM_ARB_PERF_EN defined: 10 cycles of dual request -> perf_conflict_cnt=10 and perf_core_cnt + perf_dma_cnt = 10.
